// File: rtl/mul_wb_merge_pkg.sv
// Shared definitions for the multiply writeback merge block: default
// geometry, port-grant encoding and the back-pressure threshold helper.
package mul_wb_merge_pkg;

    localparam int REG_SIZE_DEF = 32;
    localparam int REG_ADDR_DEF = 5;
    localparam int MUL_LAT_DEF  = 4;
    localparam int DEPTH_DEF    = 8;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        GRANT_IDLE = 2'd0,
        GRANT_WB   = 2'd1,
        GRANT_POP  = 2'd2,
        GRANT_BYP  = 2'd3
    } grant_e;

    // Highest occupancy that still leaves room for every multiply already
    // in flight when the stall is raised.
    function automatic int stall_threshold(input int depth, input int mul_lat);
        return depth - mul_lat - 1;
    endfunction

endpackage

// File: rtl/mul_wb_fifo.sv
// In-order buffer for multiply results that lost the write port.
// Circular storage with wrap-bit pointers, per-entry valid bits that can be
// cleared by a WAW squash, and parallel destination compares for hazards.
module mul_wb_fifo
    import mul_wb_merge_pkg::*;
#(
    parameter int REG_SIZE = REG_SIZE_DEF,
    parameter int REG_ADDR = REG_ADDR_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                push,
    input  logic [REG_ADDR-1:0] push_wreg,
    input  logic [REG_SIZE-1:0] push_data,
    input  logic                pop,
    input  logic                sq_en,
    input  logic [REG_ADDR-1:0] sq_wreg,
    input  logic [REG_ADDR-1:0] cmp_a,
    input  logic [REG_ADDR-1:0] cmp_b,
    output logic                head_valid,
    output logic [REG_ADDR-1:0] head_wreg,
    output logic [REG_SIZE-1:0] head_data,
    output logic [AW:0]         count_next,
    output logic                empty,
    output logic                full,
    output logic                hit_a,
    output logic                hit_b
);

    logic [AW:0]         head_r;
    logic [AW:0]         tail_r;
    logic                valid_r [DEPTH];
    logic [REG_ADDR-1:0] wreg_r  [DEPTH];
    logic [REG_SIZE-1:0] data_r  [DEPTH];

    logic [AW:0]   count_s;
    logic          push_ok_s;
    logic          pop_ok_s;
    logic [AW-1:0] head_idx_s;
    logic [AW-1:0] tail_idx_s;

    assign count_s    = tail_r - head_r;
    assign empty      = (count_s == {(AW+1){1'b0}});
    assign full       = (count_s == (AW+1)'(DEPTH));
    // A full buffer still accepts a push when the head leaves the same cycle.
    assign push_ok_s  = push & (~full | pop);
    assign pop_ok_s   = pop & ~empty;
    assign count_next = count_s + {{AW{1'b0}}, push_ok_s} - {{AW{1'b0}}, pop_ok_s};
    assign head_idx_s = head_r[AW-1:0];
    assign tail_idx_s = tail_r[AW-1:0];

    assign head_valid = valid_r[head_idx_s];
    assign head_wreg  = wreg_r[head_idx_s];
    assign head_data  = data_r[head_idx_s];

    // Advance head/tail pointers on accepted pops and pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r <= {(AW+1){1'b0}};
            tail_r <= {(AW+1){1'b0}};
        end else begin
            if (pop_ok_s) begin
                head_r <= head_r + {{AW{1'b0}}, 1'b1};
            end
            if (push_ok_s) begin
                tail_r <= tail_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

    // Entry storage: push writes the tail slot, pop and WAW squash clear valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                wreg_r[i]  <= {REG_ADDR{1'b0}};
                data_r[i]  <= {REG_SIZE{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (push_ok_s && (tail_idx_s == AW'(i))) begin
                    valid_r[i] <= 1'b1;
                    wreg_r[i]  <= push_wreg;
                    data_r[i]  <= push_data;
                end else if (pop_ok_s && (head_idx_s == AW'(i))) begin
                    valid_r[i] <= 1'b0;
                end else if (sq_en && (wreg_r[i] == sq_wreg)) begin
                    valid_r[i] <= 1'b0;
                end else begin
                    valid_r[i] <= valid_r[i];
                end
            end
        end
    end

    // Parallel destination compare against every live entry for hazard lookup.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_r[i] && (wreg_r[i] == cmp_a)) begin
                hit_a = 1'b1;
            end else begin
                hit_a = hit_a;
            end
            if (valid_r[i] && (wreg_r[i] == cmp_b)) begin
                hit_b = 1'b1;
            end else begin
                hit_b = hit_b;
            end
        end
    end

endmodule

// File: rtl/mul_wb_merge.sv
// Merges the multiply pipeline's results onto the register-file write port
// shared with main-pipeline writeback. Writeback always wins; displaced
// multiply results queue in order and drain on idle cycles.
module mul_wb_merge
    import mul_wb_merge_pkg::*;
#(
    parameter int REG_SIZE = REG_SIZE_DEF,
    parameter int REG_ADDR = REG_ADDR_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int MUL_LAT  = MUL_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                mul_regwrite_in,
    input  logic [REG_ADDR-1:0] mul_wreg_in,
    input  logic [REG_SIZE-1:0] mul_result_in,
    input  logic                mul_overflow_in,
    input  logic                wb_regwrite_in,
    input  logic [REG_ADDR-1:0] wb_wreg_in,
    input  logic [REG_SIZE-1:0] wb_data_in,
    input  logic [REG_ADDR-1:0] hz_raddr_a,
    input  logic [REG_ADDR-1:0] hz_raddr_b,
    input  logic                ovf_clr,
    output logic                rf_we,
    output logic [REG_ADDR-1:0] rf_waddr,
    output logic [REG_SIZE-1:0] rf_wdata,
    output logic                hz_hit_a,
    output logic                hz_hit_b,
    output logic                mul_stall_out,
    output logic                mul_ovf_flag,
    output logic                fifo_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] STALL_TH = (AW+1)'(stall_threshold(DEPTH, MUL_LAT));

    logic                mul_valid_s;
    logic                mul_live_s;
    logic                wb_valid_s;
    logic                ovf_set_s;
    grant_e              grant_s;
    logic                push_s;
    logic                pop_s;
    logic                push_drop_s;
    logic                we_nxt_s;
    logic [REG_ADDR-1:0] waddr_nxt_s;
    logic [REG_SIZE-1:0] wdata_nxt_s;

    logic                head_valid_s;
    logic [REG_ADDR-1:0] head_wreg_s;
    logic [REG_SIZE-1:0] head_data_s;
    logic [AW:0]         count_next_s;
    logic                fifo_empty_s;
    logic                fifo_full_s;
    logic                fifo_hit_a_s;
    logic                fifo_hit_b_s;

    // Register 0 is never written; overflowed multiplies are discarded.
    assign mul_valid_s = mul_regwrite_in & ~mul_overflow_in & (mul_wreg_in != {REG_ADDR{1'b0}});
    assign wb_valid_s  = wb_regwrite_in & (wb_wreg_in != {REG_ADDR{1'b0}});
    assign ovf_set_s   = mul_regwrite_in & mul_overflow_in;
    // A same-cycle multiply to the writeback's destination is older, so it dies.
    assign mul_live_s  = mul_valid_s & ~(wb_valid_s & (mul_wreg_in == wb_wreg_in));

    // Port arbitration: writeback, then buffered head, then bypass.
    always_comb begin
        grant_s = GRANT_IDLE;
        if (wb_valid_s) begin
            grant_s = GRANT_WB;
        end else if (!fifo_empty_s) begin
            grant_s = GRANT_POP;
        end else if (mul_live_s) begin
            grant_s = GRANT_BYP;
        end else begin
            grant_s = GRANT_IDLE;
        end
    end

    // Select the next write-port contents for the granted source.
    always_comb begin
        we_nxt_s    = 1'b0;
        waddr_nxt_s = {REG_ADDR{1'b0}};
        wdata_nxt_s = {REG_SIZE{1'b0}};
        pop_s       = 1'b0;
        case (grant_s)
            GRANT_WB: begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = wb_wreg_in;
                wdata_nxt_s = wb_data_in;
            end
            GRANT_POP: begin
                // A squashed head still consumes its slot as a no-write cycle.
                pop_s       = 1'b1;
                we_nxt_s    = head_valid_s;
                waddr_nxt_s = head_valid_s ? head_wreg_s : {REG_ADDR{1'b0}};
                wdata_nxt_s = head_valid_s ? head_data_s : {REG_SIZE{1'b0}};
            end
            GRANT_BYP: begin
                we_nxt_s    = 1'b1;
                waddr_nxt_s = mul_wreg_in;
                wdata_nxt_s = mul_result_in;
            end
            default: begin
                we_nxt_s    = 1'b0;
                waddr_nxt_s = {REG_ADDR{1'b0}};
                wdata_nxt_s = {REG_SIZE{1'b0}};
            end
        endcase
    end

    assign push_s      = mul_live_s & (grant_s != GRANT_BYP);
    assign push_drop_s = push_s & fifo_full_s & ~pop_s;

    mul_wb_fifo #(
        .REG_SIZE (REG_SIZE),
        .REG_ADDR (REG_ADDR),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .push_wreg  (mul_wreg_in),
        .push_data  (mul_result_in),
        .pop        (pop_s),
        .sq_en      (wb_valid_s),
        .sq_wreg    (wb_wreg_in),
        .cmp_a      (hz_raddr_a),
        .cmp_b      (hz_raddr_b),
        .head_valid (head_valid_s),
        .head_wreg  (head_wreg_s),
        .head_data  (head_data_s),
        .count_next (count_next_s),
        .empty      (fifo_empty_s),
        .full       (fifo_full_s),
        .hit_a      (fifo_hit_a_s),
        .hit_b      (fifo_hit_b_s)
    );

    assign hz_hit_a = (hz_raddr_a != {REG_ADDR{1'b0}}) &
                      (fifo_hit_a_s | (mul_valid_s & (mul_wreg_in == hz_raddr_a)));
    assign hz_hit_b = (hz_raddr_b != {REG_ADDR{1'b0}}) &
                      (fifo_hit_b_s | (mul_valid_s & (mul_wreg_in == hz_raddr_b)));

    // Register-file write port registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= {REG_ADDR{1'b0}};
            rf_wdata <= {REG_SIZE{1'b0}};
        end else begin
            rf_we    <= we_nxt_s;
            rf_waddr <= waddr_nxt_s;
            rf_wdata <= wdata_nxt_s;
        end
    end

    // Back-pressure from next-cycle occupancy, plus sticky status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_stall_out <= 1'b0;
            mul_ovf_flag  <= 1'b0;
            fifo_err      <= 1'b0;
        end else begin
            mul_stall_out <= (count_next_s > STALL_TH);
            if (ovf_set_s) begin
                mul_ovf_flag <= 1'b1;
            end else if (ovf_clr) begin
                mul_ovf_flag <= 1'b0;
            end else begin
                mul_ovf_flag <= mul_ovf_flag;
            end
            if (push_drop_s) begin
                fifo_err <= 1'b1;
            end else begin
                fifo_err <= fifo_err;
            end
        end
    end

endmodule

// File: tb/tb_mul_wb_merge.sv
// Self-checking bench for mul_wb_merge: directed scenarios plus a random
// run compared against a queue-based behavioural model of the merge rules.
module tb_mul_wb_merge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mul_regwrite_in;
    logic [4:0]  mul_wreg_in;
    logic [31:0] mul_result_in;
    logic        mul_overflow_in;
    logic        wb_regwrite_in;
    logic [4:0]  wb_wreg_in;
    logic [31:0] wb_data_in;
    logic [4:0]  hz_raddr_a;
    logic [4:0]  hz_raddr_b;
    logic        ovf_clr;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        hz_hit_a;
    logic        hz_hit_b;
    logic        mul_stall_out;
    logic        mul_ovf_flag;
    logic        fifo_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        bit        v;
        bit [4:0]  r;
        bit [31:0] d;
    } ent_t;

    ent_t      mq[$];
    bit        exp_we;
    bit [4:0]  exp_waddr;
    bit [31:0] exp_wdata;
    bit        exp_stall;
    bit        exp_ovf;
    bit        exp_err;

    mul_wb_merge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mul_regwrite_in (mul_regwrite_in),
        .mul_wreg_in     (mul_wreg_in),
        .mul_result_in   (mul_result_in),
        .mul_overflow_in (mul_overflow_in),
        .wb_regwrite_in  (wb_regwrite_in),
        .wb_wreg_in      (wb_wreg_in),
        .wb_data_in      (wb_data_in),
        .hz_raddr_a      (hz_raddr_a),
        .hz_raddr_b      (hz_raddr_b),
        .ovf_clr         (ovf_clr),
        .rf_we           (rf_we),
        .rf_waddr        (rf_waddr),
        .rf_wdata        (rf_wdata),
        .hz_hit_a        (hz_hit_a),
        .hz_hit_b        (hz_hit_b),
        .mul_stall_out   (mul_stall_out),
        .mul_ovf_flag    (mul_ovf_flag),
        .fifo_err        (fifo_err)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        mul_regwrite_in = 1'b0;
        mul_wreg_in     = 5'd0;
        mul_result_in   = 32'd0;
        mul_overflow_in = 1'b0;
        wb_regwrite_in  = 1'b0;
        wb_wreg_in      = 5'd0;
        wb_data_in      = 32'd0;
        hz_raddr_a      = 5'd0;
        hz_raddr_b      = 5'd0;
        ovf_clr         = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        exp_we    = 1'b0;
        exp_waddr = 5'd0;
        exp_wdata = 32'd0;
        exp_stall = 1'b0;
        exp_ovf   = 1'b0;
        exp_err   = 1'b0;
    endtask

    // Pending-write lookup: any live queued write or the live incoming multiply.
    function automatic bit model_hit(input bit [4:0] a);
        if (a == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].r == a) return 1'b1;
        return mul_regwrite_in && !mul_overflow_in && mul_wreg_in != 5'd0 && mul_wreg_in == a;
    endfunction

    // Apply one cycle of the merge rules to the model, then clock the DUT.
    task automatic step();
        bit   mv;
        bit   wv;
        ent_t e;
        mv = mul_regwrite_in && !mul_overflow_in && mul_wreg_in != 5'd0;
        wv = wb_regwrite_in && wb_wreg_in != 5'd0;
        if (mul_regwrite_in && mul_overflow_in) exp_ovf = 1'b1;
        else if (ovf_clr) exp_ovf = 1'b0;
        exp_we = 1'b0;
        if (wv) begin
            exp_we = 1'b1; exp_waddr = wb_wreg_in; exp_wdata = wb_data_in;
            foreach (mq[i]) if (mq[i].r == wb_wreg_in) mq[i].v = 1'b0;
            if (mv && mul_wreg_in != wb_wreg_in) begin
                if (mq.size() < 8) mq.push_back({1'b1, mul_wreg_in, mul_result_in});
                else exp_err = 1'b1;
            end
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = e.v; exp_waddr = e.r; exp_wdata = e.d;
            if (mv) mq.push_back({1'b1, mul_wreg_in, mul_result_in});
        end else if (mv) begin
            exp_we = 1'b1; exp_waddr = mul_wreg_in; exp_wdata = mul_result_in;
        end
        exp_stall = (mq.size() > 3);
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #3;
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%0b exp=0", rf_we); end
        total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
        total++; if (rf_wdata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        total++; if (mul_stall_out !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b exp=0", mul_stall_out); end
        total++; if (mul_ovf_flag !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b exp=0", mul_ovf_flag); end
        total++; if (fifo_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", fifo_err); end
        mul_regwrite_in = 1'b1; mul_wreg_in = 5'd4; hz_raddr_a = 5'd4; hz_raddr_b = 5'd3;
        #1;
        total++; if (hz_hit_a !== 1'b1) begin bad++; $display("FAIL reset_hz_incoming got=%0b exp=1", hz_hit_a); end
        total++; if (hz_hit_b !== 1'b0) begin bad++; $display("FAIL reset_hz_other got=%0b exp=0", hz_hit_b); end
        idle_inputs();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL reset_idle_we got=%0b exp=0", rf_we); end
    endtask

    task automatic test_bypass();
        idle_inputs();
        mul_regwrite_in = 1'b1; mul_wreg_in = 5'd5; mul_result_in = 32'h0000_0012;
        step();
        total++; if (rf_we !== 1'b1) begin bad++; $display("FAIL byp_we got=%0b exp=1", rf_we); end
        total++; if (rf_waddr !== 5'd5) begin bad++; $display("FAIL byp_waddr got=%0d exp=5", rf_waddr); end
        total++; if (rf_wdata !== 32'h12) begin bad++; $display("FAIL byp_wdata got=%h exp=12", rf_wdata); end
        idle_inputs();
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL byp_empty_we got=%0b exp=0", rf_we); end
        total++; if (mul_stall_out !== 1'b0) begin bad++; $display("FAIL byp_stall got=%0b exp=0", mul_stall_out); end
    endtask

    task automatic test_wb_priority();
        idle_inputs();
        wb_regwrite_in = 1'b1; wb_wreg_in = 5'd3; wb_data_in = 32'h0000_AAAA;
        mul_regwrite_in = 1'b1; mul_wreg_in = 5'd7; mul_result_in = 32'h0000_0055;
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAAAA) begin
            bad++; $display("FAIL prio_wb got=%0b/%0d/%h exp=1/3/aaaa", rf_we, rf_waddr, rf_wdata); end
        idle_inputs();
        hz_raddr_b = 5'd7;
        #1;
        total++; if (hz_hit_b !== 1'b1) begin bad++; $display("FAIL prio_hz_buffered got=%0b exp=1", hz_hit_b); end
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h55) begin
            bad++; $display("FAIL prio_mul got=%0b/%0d/%h exp=1/7/55", rf_we, rf_waddr, rf_wdata); end
        #1;
        total++; if (hz_hit_b !== 1'b0) begin bad++; $display("FAIL prio_hz_popped got=%0b exp=0", hz_hit_b); end
    endtask

    task automatic test_squash();
        idle_inputs();
        wb_regwrite_in = 1'b1; wb_wreg_in = 5'd1; wb_data_in = 32'h1;
        mul_regwrite_in = 1'b1; mul_wreg_in = 5'd9; mul_result_in = 32'h11;
        step();
        idle_inputs();
        wb_regwrite_in = 1'b1; wb_wreg_in = 5'd9; wb_data_in = 32'h22; hz_raddr_a = 5'd9;
        #1;
        total++; if (hz_hit_a !== 1'b1) begin bad++; $display("FAIL sq_hz_before got=%0b exp=1", hz_hit_a); end
        step();
        total++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'h22) begin
            bad++; $display("FAIL sq_wb got=%0b/%0d/%h exp=1/9/22", rf_we, rf_waddr, rf_wdata); end
        idle_inputs();
        hz_raddr_a = 5'd9;
        #1;
        total++; if (hz_hit_a !== 1'b0) begin bad++; $display("FAIL sq_hz_after got=%0b exp=0", hz_hit_a); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sq_slot_pop got=%0b exp=0", rf_we); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL sq_after_pop got=%0b exp=0", rf_we); end
    endtask

    task automatic test_stall_drain();
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            wb_regwrite_in = 1'b1; wb_wreg_in = 5'(20 + k); wb_data_in = 32'hB000 + 32'(k);
            mul_regwrite_in = 1'b1; mul_wreg_in = 5'(10 + k); mul_result_in = 32'hC000 + 32'(k);
            step();
            total++; if (rf_waddr !== 5'(20 + k) || rf_we !== 1'b1) begin
                bad++; $display("FAIL stall_wb%0d got=%0b/%0d exp=1/%0d", k, rf_we, rf_waddr, 20 + k); end
            total++; if (mul_stall_out !== (k >= 3)) begin
                bad++; $display("FAIL stall_rise%0d got=%0b exp=%0b", k, mul_stall_out, k >= 3); end
        end
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            step();
            total++; if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + k) || rf_wdata !== 32'hC000 + 32'(k)) begin
                bad++; $display("FAIL drain%0d got=%0b/%0d/%h exp=1/%0d/%h", k, rf_we, rf_waddr, rf_wdata, 10 + k, 32'hC000 + 32'(k)); end
            total++; if (mul_stall_out !== (k == 0)) begin
                bad++; $display("FAIL drain_stall%0d got=%0b exp=%0b", k, mul_stall_out, k == 0); end
        end
        idle_inputs();
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL drain_done got=%0b exp=0", rf_we); end
    endtask

    task automatic test_ovf_r0();
        idle_inputs();
        mul_regwrite_in = 1'b1; mul_overflow_in = 1'b1; mul_wreg_in = 5'd6; mul_result_in = 32'h99; hz_raddr_a = 5'd6;
        #1;
        total++; if (hz_hit_a !== 1'b0) begin bad++; $display("FAIL ovf_hz got=%0b exp=0", hz_hit_a); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL ovf_nowrite got=%0b exp=0", rf_we); end
        total++; if (mul_ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_set got=%0b exp=1", mul_ovf_flag); end
        idle_inputs(); ovf_clr = 1'b1;
        step();
        total++; if (mul_ovf_flag !== 1'b0) begin bad++; $display("FAIL ovf_clr got=%0b exp=0", mul_ovf_flag); end
        idle_inputs(); ovf_clr = 1'b1; mul_regwrite_in = 1'b1; mul_overflow_in = 1'b1; mul_wreg_in = 5'd2;
        step();
        total++; if (mul_ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_set_wins got=%0b exp=1", mul_ovf_flag); end
        idle_inputs(); ovf_clr = 1'b1;
        step();
        idle_inputs();
        mul_regwrite_in = 1'b1; mul_wreg_in = 5'd0; mul_result_in = 32'h77; hz_raddr_a = 5'd0;
        #1;
        total++; if (hz_hit_a !== 1'b0) begin bad++; $display("FAIL r0_hz got=%0b exp=0", hz_hit_a); end
        step();
        total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL r0_nowrite got=%0b exp=0", rf_we); end
    endtask

    task automatic test_full_reset();
        for (int k = 0; k < 9; k++) begin
            idle_inputs();
            wb_regwrite_in = 1'b1; wb_wreg_in = 5'(20 + k); wb_data_in = 32'hE00 + 32'(k);
            mul_regwrite_in = 1'b1; mul_wreg_in = 5'(1 + k); mul_result_in = 32'hD00 + 32'(k);
            step();
            total++; if (fifo_err !== (k == 8)) begin
                bad++; $display("FAIL full_err%0d got=%0b exp=%0b", k, fifo_err, k == 8); end
        end
        for (int k = 0; k < 2; k++) begin
            idle_inputs();
            step();
            total++; if (rf_we !== 1'b1 || rf_waddr !== 5'(1 + k) || rf_wdata !== 32'hD00 + 32'(k)) begin
                bad++; $display("FAIL full_drain%0d got=%0b/%0d/%h exp=1/%0d", k, rf_we, rf_waddr, rf_wdata, 1 + k); end
        end
        rst_n = 1'b0;
        #1;
        total++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            bad++; $display("FAIL midrst_rf got=%0b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata); end
        total++; if (mul_stall_out !== 1'b0 || fifo_err !== 1'b0 || mul_ovf_flag !== 1'b0) begin
            bad++; $display("FAIL midrst_flags got=%0b/%0b/%0b exp=0/0/0", mul_stall_out, fifo_err, mul_ovf_flag); end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (rf_we !== 1'b0) begin bad++; $display("FAIL midrst_quiet%0d got=%0b exp=0", k, rf_we); end
        end
    endtask

    task automatic test_random();
        bit ea;
        bit eb;
        for (int n = 0; n < 400; n++) begin
            idle_inputs();
            wb_regwrite_in  = ($urandom_range(0, 99) < 45);
            wb_wreg_in      = 5'($urandom_range(0, 7));
            wb_data_in      = $urandom;
            mul_regwrite_in = ($urandom_range(0, 99) < 60);
            mul_overflow_in = ($urandom_range(0, 99) < 6);
            mul_wreg_in     = 5'($urandom_range(0, 7));
            mul_result_in   = $urandom;
            hz_raddr_a      = 5'($urandom_range(0, 7));
            hz_raddr_b      = 5'($urandom_range(0, 7));
            ovf_clr         = ($urandom_range(0, 99) < 10);
            #1;
            ea = model_hit(hz_raddr_a);
            eb = model_hit(hz_raddr_b);
            total++; if (hz_hit_a !== ea || hz_hit_b !== eb) begin
                bad++; $display("FAIL rnd_hz%0d got=%0b%0b exp=%0b%0b", n, hz_hit_a, hz_hit_b, ea, eb); end
            step();
            total++; if (rf_we !== exp_we || (exp_we && (rf_waddr !== exp_waddr || rf_wdata !== exp_wdata))) begin
                bad++; $display("FAIL rnd_rf%0d got=%0b/%0d/%h exp=%0b/%0d/%h", n, rf_we, rf_waddr, rf_wdata, exp_we, exp_waddr, exp_wdata); end
            total++; if (mul_stall_out !== exp_stall || mul_ovf_flag !== exp_ovf || fifo_err !== exp_err) begin
                bad++; $display("FAIL rnd_flags%0d got=%0b%0b%0b exp=%0b%0b%0b", n, mul_stall_out, mul_ovf_flag, fifo_err, exp_stall, exp_ovf, exp_err); end
        end
    endtask

    initial begin
        idle_inputs();
        model_reset();
        rst_n = 1'b1;
        #2;
        test_reset();
        test_bypass();
        test_wb_priority();
        test_squash();
        test_stall_drain();
        test_ovf_r0();
        test_full_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
